// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C_Controller between NREQ command sources.
// Grants round-robin, runs GO/END, checks ACK, times out, pulses done/err.
// Ports: clk_i2c, reset_n (async, active low);
//   req_valid/req_data in, req_grant/req_done/req_err out (per requester);
//   i2c_data/i2c_go out, i2c_end/i2c_ack in (controller side); busy out.
// Optional macro I2C_ARB_RETRY_EN: re-issue a NACKed command up to MAX_RETRY times.
module i2c_cmd_arbiter #(
   parameter int NREQ      = 3,
   parameter int MAX_RETRY = 2,
   parameter int TIMEOUT   = 1023
) (
   input  logic [0:0]         clk_i2c,
   input  logic [0:0]         reset_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [24*NREQ-1:0] req_data,
   output logic [NREQ-1:0]    req_grant,
   output logic [NREQ-1:0]    req_done,
   output logic               req_err,
   output logic [23:0]        i2c_data,
   output logic               i2c_go,
   input  logic               i2c_end,
   input  logic [2:0]         i2c_ack,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [9:0] TMO = 10'(TIMEOUT);

   if (NREQ < 2 || NREQ > 8 || MAX_RETRY < 0 || MAX_RETRY > 15 ||
       TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_chk
      $error("i2c_cmd_arbiter: parameter out of range");
   end

`ifdef I2C_ARB_RETRY_EN
   localparam logic [3:0] MR = 4'(MAX_RETRY);
   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_LO, WAIT_HI, CHECK, GAP, DONE
   } state_t;
   logic [3:0] retry_cnt;
`else
   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_LO, WAIT_HI, CHECK, DONE
   } state_t;
`endif

   state_t            state;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     win;
   logic [PW-1:0]     off;
   logic [PW:0]       sum;
   logic [NREQ-1:0]   rot;
   logic [NREQ-1:0]   win_oh;
   logic [NREQ-1:0]   owner_oh;
   logic [23:0]       sel_data;
   logic [9:0]        tmo_cnt;
   logic [2:0]        ack_q;

   // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
   always_comb begin
      rot = (req_valid >> rr_ptr) |
            (req_valid << (NREQ - int'(rr_ptr)));
      off = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (rot[j]) off = PW'(j);
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      win = sum[PW-1:0];
   end

   always_comb begin
      win_oh   = '0;
      owner_oh = '0;
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         win_oh[j]   = (win == PW'(j));
         owner_oh[j] = (owner == PW'(j));
         if (win == PW'(j)) sel_data = req_data[24*j +: 24];
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         tmo_cnt   <= '0;
         ack_q     <= '0;
         req_grant <= '0;
         req_done  <= '0;
         req_err   <= 1'b0;
         i2c_data  <= '0;
         i2c_go    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         req_grant <= '0;
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  req_grant <= win_oh;
                  i2c_data  <= sel_data;
                  owner     <= win;
                  rr_ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               i2c_go  <= 1'b1;
               tmo_cnt <= '0;
               state   <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!i2c_end) begin
                  tmo_cnt <= '0;
                  state   <= WAIT_HI;
               end else if (tmo_cnt == TMO) begin
                  i2c_go   <= 1'b0;
                  req_done <= owner_oh;
                  req_err  <= 1'b1;
                  tmo_cnt  <= '0;
                  state    <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 10'd1;
               end
            end
            WAIT_HI: begin
               if (i2c_end) begin
                  ack_q   <= i2c_ack;
                  tmo_cnt <= '0;
                  state   <= CHECK;
               end else if (tmo_cnt == TMO) begin
                  i2c_go   <= 1'b0;
                  req_done <= owner_oh;
                  req_err  <= 1'b1;
                  tmo_cnt  <= '0;
                  state    <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 10'd1;
               end
            end
            CHECK: begin
               i2c_go <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
               if ((ack_q != 3'b000) && (retry_cnt < MR)) begin
                  retry_cnt <= retry_cnt + 4'd1;
                  state     <= GAP;
               end else begin
                  req_done <= owner_oh;
                  req_err  <= |ack_q;
                  state    <= DONE;
               end
`else
               req_done <= owner_oh;
               req_err  <= |ack_q;
               state    <= DONE;
`endif
            end
`ifdef I2C_ARB_RETRY_EN
            GAP: begin
               state <= ISSUE;
            end
`endif
            DONE: begin
               req_done <= '0;
               req_err  <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
               retry_cnt <= '0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed bench for i2c_cmd_arbiter with an
// I2C controller responder and a transaction-level reference model.
module tb_i2c_cmd_arbiter;

   localparam int NREQ      = 3;
   localparam int MAX_RETRY = 2;
   localparam int TIMEOUT   = 1023;
`ifdef I2C_ARB_RETRY_EN
   localparam int TRIES     = MAX_RETRY + 1;
   localparam int NACK_GOS  = 3;
   localparam int NA_GOS    = 2;
   localparam int NA_ERR    = 0;
`else
   localparam int TRIES     = 1;
   localparam int NACK_GOS  = 1;
   localparam int NA_GOS    = 1;
   localparam int NA_ERR    = 1;
`endif

   typedef struct {
      int attempts;
      bit err;
      bit tmo;
   } exp_t;

   logic                clk_i2c = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req_valid;
   logic [24*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_grant;
   logic [NREQ-1:0]     req_done;
   logic                req_err;
   logic [23:0]         i2c_data;
   logic                i2c_go;
   logic                i2c_end;
   logic [2:0]          i2c_ack;
   logic                busy;

   i2c_cmd_arbiter #(
      .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i2c(clk_i2c), .reset_n(reset_n),
      .req_valid(req_valid), .req_data(req_data),
      .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
      .i2c_data(i2c_data), .i2c_go(i2c_go),
      .i2c_end(i2c_end), .i2c_ack(i2c_ack), .busy(busy)
   );

   always #5 clk_i2c = ~clk_i2c;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          last_attempts = 0;
   int          last_err = 0;
   int          grant_log[$];
   exp_t        exp_q[$];
   logic [2:0]  ack_q[$];
   bit          hang = 1'b0;
   logic [NREQ-1:0] auto_drop = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (((int'(v) >> ((p + k) % NREQ)) & 1) == 1) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int slice(input int w);
      logic [24*NREQ-1:0] t;
      t = req_data >> (24 * w);
      return int'(t[23:0]);
   endfunction

   // Outcome of one command given the queued controller ACK answers.
   function automatic exp_t outcome();
      exp_t r;
      logic [2:0] a;
      bit fin;
      r.tmo = 1'b0;
      r.err = 1'b1;
      r.attempts = TRIES;
      fin = 1'b0;
      for (int k = 0; k < TRIES; k++) begin
         a = (k < ack_q.size()) ? ack_q[k] : 3'b000;
         if (!fin && a == 3'b000) begin
            r.attempts = k + 1;
            r.err = 1'b0;
            fin = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic exp_t plain(input bit err, input bit tmo);
      exp_t r;
      r.attempts = 1;
      r.err = err;
      r.tmo = tmo;
      return r;
   endfunction

   // I2C controller responder: END drops after GO, rises 3 cycles later.
   int rs;
   int rcnt;
   initial begin
      i2c_end = 1'b1;
      i2c_ack = 3'b000;
      rs = 0;
      rcnt = 0;
      forever begin
         @(posedge clk_i2c);
         #1;
         if (!reset_n) begin
            rs = 0;
            i2c_end = 1'b1;
            i2c_ack = 3'b000;
         end else begin
            case (rs)
               0: if (i2c_go) rs = 1;
               1: begin
                  if (!i2c_go) rs = 0;
                  else if (!hang) begin
                     i2c_end = 1'b0;
                     rcnt = 0;
                     rs = 2;
                  end
               end
               2: begin
                  rcnt++;
                  if (rcnt == 3) begin
                     i2c_end = 1'b1;
                     if (ack_q.size() > 0) i2c_ack = ack_q.pop_front();
                     else i2c_ack = 3'b000;
                     rs = 3;
                  end
               end
               3: if (!i2c_go) rs = 0;
               default: rs = 0;
            endcase
         end
      end
   end

   // Reference model and per-cycle compare.
   initial begin
      bit in_xfer, prev_idle, prev_go, seen_low, g_exp;
      logic [NREQ-1:0] prev_valid;
      int mrr, owner_m, attempts_m, grant_cyc, go_rise, end_cyc, w;
      exp_t e;
      in_xfer = 0; prev_idle = 1; prev_go = 0; seen_low = 0;
      prev_valid = '0; mrr = 0; owner_m = 0; attempts_m = 0;
      grant_cyc = 0; go_rise = 0; end_cyc = 0;
      forever begin
         @(negedge clk_i2c);
         cyc++;
         if (!reset_n) begin
            in_xfer = 0; mrr = 0; prev_idle = 1; prev_go = 0;
            seen_low = 0;
            exp_q.delete();
            prev_valid = req_valid;
         end else begin
            g_exp = prev_idle && (prev_valid != '0);
            chk("grant_present", int'(req_grant != '0), int'(g_exp));
            if (req_grant != '0) begin
               w = rr_pick(prev_valid, mrr);
               chk("grant_vec", int'(req_grant), (w < 0) ? 0 : (1 << w));
               if (w >= 0) begin
                  chk("grant_data", int'(i2c_data), slice(w));
                  owner_m = w;
                  mrr = (w + 1) % NREQ;
               end
               grant_log.push_back(w);
               in_xfer = 1; attempts_m = 0; grant_cyc = cyc;
               go_rise = -1; end_cyc = -1000; seen_low = 0;
            end
            if (i2c_go && !prev_go) begin
               attempts_m++;
               seen_low = 0;
               go_rise = cyc;
               if (attempts_m == 1) chk("go_latency", cyc - grant_cyc, 1);
            end
            if (i2c_go && !i2c_end) seen_low = 1;
            else if (i2c_go && i2c_end && seen_low) begin
               end_cyc = cyc;
               seen_low = 0;
            end
            chk("busy", int'(busy), int'(in_xfer));
            if (!in_xfer) chk("go_idle", int'(i2c_go), 0);
            if (req_done != '0) begin
               done_cnt++;
               if (!in_xfer || exp_q.size() == 0) begin
                  chk("done_unexpected", int'(req_done), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_vec", int'(req_done), 1 << owner_m);
                  chk("done_err", int'(req_err), int'(e.err));
                  chk("done_attempts", attempts_m, e.attempts);
                  chk("go_at_done", int'(i2c_go), 0);
                  if (e.tmo) chk("tmo_len", cyc - go_rise, TIMEOUT + 1);
                  else chk("done_latency", cyc - end_cyc, 2);
                  last_attempts = attempts_m;
                  last_err = int'(req_err);
               end
            end
            prev_idle = !in_xfer;
            if (req_done != '0) in_xfer = 0;
            prev_valid = req_valid;
            prev_go = i2c_go;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i2c);
      #1;
      req_valid = req_valid & ~(req_grant & auto_drop);
   endtask

   task automatic wait_done(input int target, input int budget);
      int c = 0;
      while ((done_cnt < target || busy) && c < budget) begin
         tick();
         c++;
      end
      chk("wait_done", done_cnt, target);
   endtask

   initial begin
      int n, base, t, dc;
      reset_n = 1'b0;
      req_valid = '0;
      req_data = {24'h34_0A_17, 24'h34_0E_42, 24'h34_0C_00};
      repeat (3) tick();
      chk("rst_grant", int'(req_grant), 0);
      chk("rst_done", int'(req_done), 0);
      chk("rst_err", int'(req_err), 0);
      chk("rst_go", int'(i2c_go), 0);
      chk("rst_data", int'(i2c_data), 0);
      chk("rst_busy", int'(busy), 0);
      reset_n = 1'b1;
      tick();
      tick();

      // contention: all three held valid for six transfers
      base = grant_log.size();
      t = done_cnt + 6;
      for (int i = 0; i < 6; i++) exp_q.push_back(plain(1'b0, 1'b0));
      auto_drop = '0;
      req_valid = 3'b111;
      n = 0;
      for (int c = 0; c < 400 && n < 6; c++) begin
         tick();
         if (req_grant != '0) n++;
      end
      req_valid = '0;
      chk("cont_grants", n, 6);
      wait_done(t, 200);
      for (int i = 0; i < 6; i++) begin
         if (base + i < grant_log.size())
            chk("cont_order", grant_log[base + i], i % 3);
         else
            chk("cont_order_missing", base + i, grant_log.size());
      end

      // single request from requester 0
      auto_drop = 3'b111;
      base = grant_log.size();
      t = done_cnt + 1;
      exp_q.push_back(plain(1'b0, 1'b0));
      req_valid = 3'b001;
      wait_done(t, 100);
      if (base < grant_log.size()) chk("single_owner", grant_log[base], 0);
      else chk("single_owner_missing", base, grant_log.size());
      chk("single_data", int'(i2c_data), 32'h0034_0C00);
      chk("single_err", last_err, 0);
      chk("single_valid_dropped", int'(req_valid), 0);
      chk("single_busy", int'(busy), 0);

      // persistent NACK from requester 2
      ack_q.delete();
      ack_q.push_back(3'b010);
      ack_q.push_back(3'b010);
      ack_q.push_back(3'b010);
      exp_q.push_back(outcome());
      t = done_cnt + 1;
      req_valid = 3'b100;
      wait_done(t, 200);
      chk("nack_gos", last_attempts, NACK_GOS);
      chk("nack_err", last_err, 1);
      chk("nack_data_kept", int'(i2c_data), 32'h0034_0A17);
      ack_q.delete();

      // NACK then ACK from requester 1
      ack_q.push_back(3'b100);
      ack_q.push_back(3'b000);
      exp_q.push_back(outcome());
      t = done_cnt + 1;
      req_valid = 3'b010;
      wait_done(t, 200);
      chk("nack_ack_gos", last_attempts, NA_GOS);
      chk("nack_ack_err", last_err, NA_ERR);
      ack_q.delete();

      // timeout: END never drops for requester 0, requester 1 follows
      base = grant_log.size();
      hang = 1'b1;
      exp_q.push_back(plain(1'b1, 1'b1));
      exp_q.push_back(plain(1'b0, 1'b0));
      t = done_cnt + 1;
      req_valid = 3'b011;
      n = 0;
      while (done_cnt < t && n < 1200) begin
         tick();
         n++;
      end
      chk("tmo_done_seen", done_cnt, t);
      chk("tmo_err", last_err, 1);
      chk("tmo_gos", last_attempts, 1);
      hang = 1'b0;
      wait_done(t + 1, 200);
      if (base + 1 < grant_log.size()) begin
         chk("tmo_first", grant_log[base], 0);
         chk("tmo_next", grant_log[base + 1], 1);
      end else begin
         chk("tmo_grants_missing", grant_log.size(), base + 2);
      end

      // reset while waiting for END high
      exp_q.push_back(plain(1'b0, 1'b0));
      req_valid = 3'b010;
      n = 0;
      while (i2c_end && n < 50) begin
         tick();
         n++;
      end
      chk("rst_end_low", int'(i2c_end), 0);
      tick();
      chk("rst_pre_go", int'(i2c_go), 1);
      dc = done_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_go", int'(i2c_go), 0);
      chk("rst_mid_busy", int'(busy), 0);
      tick();
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
      chk("rst_no_done", done_cnt, dc);
      base = grant_log.size();
      for (int i = 0; i < 3; i++) exp_q.push_back(plain(1'b0, 1'b0));
      req_valid = 3'b111;
      wait_done(dc + 3, 200);
      for (int i = 0; i < 3; i++) begin
         if (base + i < grant_log.size())
            chk("rst_rr_order", grant_log[base + i], i);
         else
            chk("rst_rr_missing", base + i, grant_log.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
